// File: rtl/imm_decode_if.sv
// Handshake bundle for the immediate-decode stage: upstream instruction
// side and downstream decoded-entry side.
interface imm_decode_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm;
  logic [2:0]      imm_type;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_out;
  logic            illegal;

  modport master (
    output in_valid, instr, pc, out_ready,
    input  in_ready, out_valid, imm, imm_type, target, pc_out, illegal
  );

  modport slave (
    input  in_valid, instr, pc, out_ready,
    output in_ready, out_valid, imm, imm_type, target, pc_out, illegal
  );
endinterface

// File: rtl/imm_decode_stage.sv
// Registered RISC-V immediate generator: opcode-driven format decode, sign
// extension, pc+imm target, behind a main+skid buffer so in_ready is a flop.
module imm_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  imm_decode_if.slave  bus
);

  localparam logic [2:0] T_I    = 3'd0;
  localparam logic [2:0] T_S    = 3'd1;
  localparam logic [2:0] T_B    = 3'd2;
  localparam logic [2:0] T_J    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_NONE = 3'd5;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      imm_type;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } entry_t;

  function automatic logic signed [XLEN-1:0] sext_xlen(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  logic signed [31:0] imm32_p0;
  logic signed [XLEN-1:0] immx_p0;
  entry_t dec_p0;
  entry_t main_p1, skid_p1;
  logic   main_vld_p1, skid_vld_p1;
  logic   s;
  logic   accept, drain;

  assign s = bus.instr[31];

  always_comb begin
    dec_p0            = '0;
    imm32_p0          = '0;
    dec_p0.imm_type   = T_NONE;
    case (bus.instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
        dec_p0.imm_type = T_I;
        imm32_p0 = {{20{s}}, bus.instr[31:20]};
      end
      7'b0100011: begin
        dec_p0.imm_type = T_S;
        imm32_p0 = {{20{s}}, bus.instr[31:25], bus.instr[11:7]};
      end
      7'b1100011: begin
        dec_p0.imm_type = T_B;
        imm32_p0 = {{19{s}}, s, bus.instr[7], bus.instr[30:25], bus.instr[11:8], 1'b0};
      end
      7'b1101111: begin
        dec_p0.imm_type = T_J;
        imm32_p0 = {{11{s}}, s, bus.instr[19:12], bus.instr[20], bus.instr[30:21], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_p0.imm_type = T_U;
        imm32_p0 = {bus.instr[31:12], 12'b0};
      end
      7'b0110011: dec_p0.imm_type = T_NONE;
      default:    dec_p0.illegal  = 1'b1;
    endcase
    immx_p0       = sext_xlen(imm32_p0);
    dec_p0.imm    = immx_p0;
    dec_p0.pc     = bus.pc;
    dec_p0.target = bus.pc + immx_p0;
  end

  assign accept = bus.in_valid & ~skid_vld_p1;
  assign drain  = main_vld_p1 & bus.out_ready;

  // ---- p0 -> p1: main/skid buffer; skid only fills when main is stalled ----
  always_ff @(posedge clk) begin
    if (reset) begin
      main_vld_p1 <= 1'b0;
      skid_vld_p1 <= 1'b0;
      main_p1     <= '0;
      skid_p1     <= '0;
    end else if (flush) begin
      main_vld_p1 <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (drain) begin
      if (skid_vld_p1) begin
        main_p1     <= skid_p1;
        skid_vld_p1 <= 1'b0;
      end else if (accept) begin
        main_p1     <= dec_p0;
      end else begin
        main_vld_p1 <= 1'b0;
      end
    end else if (accept) begin
      if (!main_vld_p1) begin
        main_p1     <= dec_p0;
        main_vld_p1 <= 1'b1;
      end else begin
        skid_p1     <= dec_p0;
        skid_vld_p1 <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = ~skid_vld_p1;
  assign bus.out_valid = main_vld_p1;
  assign bus.imm       = main_p1.imm;
  assign bus.imm_type  = main_p1.imm_type;
  assign bus.target    = main_p1.target;
  assign bus.pc_out    = main_p1.pc;
  assign bus.illegal   = main_p1.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: XLEN=32 and XLEN=64 instances share stimulus and
// are checked every cycle against a queue-based reference plus literal cases.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = '0;
  logic [63:0] pc_d = '0;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  ty;
    logic [63:0] tgt;
    logic [63:0] pc;
    logic        ill;
  } ent_t;

  ent_t q[$];

  imm_decode_if #(.XLEN(32)) bus32 ();
  imm_decode_if #(.XLEN(64)) bus64 ();

  assign bus32.in_valid  = in_valid;
  assign bus32.instr     = instr;
  assign bus32.pc        = pc_d[31:0];
  assign bus32.out_ready = out_ready;
  assign bus64.in_valid  = in_valid;
  assign bus64.instr     = instr;
  assign bus64.pc        = pc_d;
  assign bus64.out_ready = out_ready;

  imm_decode_stage #(.XLEN(32)) dut32 (.clk(clk), .reset(reset), .flush(flush), .bus(bus32));
  imm_decode_stage #(.XLEN(64)) dut64 (.clk(clk), .reset(reset), .flush(flush), .bus(bus64));

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
    end
  endtask

  // Reference decode from the ISA field definitions, using integer arithmetic.
  function automatic ent_t model(input logic [31:0] i, input logic [63:0] p);
    ent_t e;
    longint v;
    v = 0;
    e.ill = 1'b0;
    case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: begin
        e.ty = 3'd0;
        v = longint'(i[31:20]);
        if (v >= 2048) v -= 4096;
      end
      7'h23: begin
        e.ty = 3'd1;
        v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
        if (v >= 2048) v -= 4096;
      end
      7'h63: begin
        e.ty = 3'd2;
        v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048
          + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      7'h6F: begin
        e.ty = 3'd3;
        v = longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096
          + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      7'h37, 7'h17: begin
        e.ty = 3'd4;
        v = longint'(i[31:12]) * 4096;
        if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000;
      end
      7'h33: e.ty = 3'd5;
      default: begin
        e.ty  = 3'd5;
        e.ill = 1'b1;
      end
    endcase
    e.imm = v;
    e.tgt = p + v;
    e.pc  = p;
    return e;
  endfunction

  always @(posedge clk) begin
    if (reset) started <= 1'b1;
    if (reset || flush) begin
      q.delete();
    end else begin : mdl
      automatic int n = q.size();
      if (n > 0 && out_ready) q.pop_front();
      if (in_valid && n < 2) q.push_back(model(instr, pc_d));
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("vld32", bus32.out_valid, q.size() > 0);
      chk("rdy32", bus32.in_ready,  q.size() < 2);
      chk("vld64", bus64.out_valid, q.size() > 0);
      chk("rdy64", bus64.in_ready,  q.size() < 2);
      if (q.size() > 0) begin
        chk("imm32", bus32.imm,      q[0].imm & 64'hFFFF_FFFF);
        chk("ty32",  bus32.imm_type, q[0].ty);
        chk("tgt32", bus32.target,   q[0].tgt & 64'hFFFF_FFFF);
        chk("pc32",  bus32.pc_out,   q[0].pc & 64'hFFFF_FFFF);
        chk("ill32", bus32.illegal,  q[0].ill);
        chk("imm64", bus64.imm,      q[0].imm);
        chk("ty64",  bus64.imm_type, q[0].ty);
        chk("tgt64", bus64.target,   q[0].tgt);
        chk("pc64",  bus64.pc_out,   q[0].pc);
        chk("ill64", bus64.illegal,  q[0].ill);
      end
    end
  end

  task automatic send(input logic [31:0] ins, input logic [63:0] p);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    instr    = ins;
    pc_d     = p;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus32.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("send_accept", ok, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic dir(input string n, input logic [31:0] ins, input logic [63:0] p,
                     input logic [31:0] ei, input logic [2:0] et,
                     input logic [31:0] eg, input logic ell);
    send(ins, p);
    @(negedge clk);
    chk({n, "_vld"}, bus32.out_valid, 1);
    chk({n, "_imm"}, bus32.imm, ei);
    chk({n, "_ty"},  bus32.imm_type, et);
    chk({n, "_tgt"}, bus32.target, eg);
    chk({n, "_ill"}, bus32.illegal, ell);
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_vld"}, bus32.out_valid, 0);
    chk({n, "_rdy"}, bus32.in_ready, 1);
    chk({n, "_imm"}, bus32.imm, 0);
    chk({n, "_ty"},  bus32.imm_type, 0);
    chk({n, "_tgt"}, bus32.target, 0);
    chk({n, "_pc"},  bus32.pc_out, 0);
    chk({n, "_ill"}, bus32.illegal, 0);
    chk({n, "_imm64"}, bus64.imm, 0);
    chk({n, "_pc64"},  bus64.pc_out, 0);
    chk({n, "_vld64"}, bus64.out_valid, 0);
  endtask

  initial begin
    logic [6:0]  ops [12];
    logic [31:0] r;
    ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h7F, 7'h0B};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    out_ready = 1'b1;
    dir("addi", 32'hFFF00093, 64'h1000, 32'hFFFF_FFFF, 3'd0, 32'h0000_0FFF, 1'b0);
    dir("beq",  32'hFE000EE3, 64'h1000, 32'hFFFF_FFFC, 3'd2, 32'h0000_0FFC, 1'b0);
    dir("jal",  32'h800000EF, 64'h1000, 32'hFFF0_0000, 3'd3, 32'hFFF0_1000, 1'b0);
    dir("lui",  32'h123450B7, 64'h1000, 32'h1234_5000, 3'd4, 32'h1234_6000, 1'b0);
    dir("add",  32'h00B50533, 64'h1000, 32'h0,         3'd5, 32'h0000_1000, 1'b0);
    dir("srai", 32'h40555513, 64'h1000, 32'h0000_0405, 3'd0, 32'h0000_1405, 1'b0);
    dir("ill",  32'h0000007F, 64'h1000, 32'h0,         3'd5, 32'h0000_1000, 1'b1);
    dir("wrap", 32'h0080006F, 64'hFFFF_FFFC, 32'h8,    3'd3, 32'h0000_0004, 1'b0);
    send(32'h800000B7, 64'h1000);
    @(negedge clk);
    chk("lui64_imm", bus64.imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui64_tgt", bus64.target, 64'hFFFF_FFFF_8000_1000);

    // Backpressure: A in main, B in skid, C held off.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(32'h00100093, 64'h2000);
    send(32'h00200093, 64'h2004);
    in_valid = 1'b1;
    instr    = 32'h00300093;
    pc_d     = 64'h2008;
    @(negedge clk);
    chk("bp_rdy", bus32.in_ready, 0);
    chk("bp_pcA", bus32.pc_out, 32'h2000);
    @(negedge clk);
    chk("bp_hold", bus32.pc_out, 32'h2000);
    out_ready = 1'b1;
    send(32'h00300093, 64'h2008);
    @(negedge clk);
    chk("bp_pcC", bus32.pc_out, 32'h2008);
    @(posedge clk);
    #1;

    // Flush with both entries full plus a pending input.
    out_ready = 1'b0;
    send(32'h00400093, 64'h3000);
    send(32'h00500093, 64'h3004);
    in_valid = 1'b1;
    instr    = 32'h00600093;
    pc_d     = 64'h3008;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fl_vld", bus32.out_valid, 0);
    chk("fl_rdy", bus32.in_ready, 1);
    // Flush while an input is actually accepted into an empty stage.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    instr    = 32'h00700093;
    pc_d     = 64'h300C;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fl2_vld", bus32.out_valid, 0);

    // Reset mid-stream.
    @(posedge clk);
    #1;
    send(32'h00800093, 64'h4000);
    send(32'h00900093, 64'h4004);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_zero("rst_mid");

    // Random traffic.
    @(posedge clk);
    #1;
    for (int n = 0; n < 10000; n++) begin
      r         = $urandom();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 299) == 0);
      instr     = {r[31:7], ops[$urandom_range(0, 11)]};
      pc_d      = {$urandom(), $urandom()};
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
